vram_arbiter: RTL

Single-port video RAM arbiter sharing one synchronous 8-bit VRAM between the VGA scan-out fetcher and the CPU bus interface. Every clock is one memory slot; the fetcher has fixed priority and a fixed 3-cycle read latency so raster timing stays deterministic. The CPU uses a request/acknowledge handshake and is served in slots the fetcher leaves idle. Sits between the VGA timing/fetch logic and the VRAM block, in the same clock domain as the pixel counters.

---
 rtl/vram_arbiter_if.sv | 35 +++
 rtl/vram_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video fetch, CPU and VRAM command signals for vram_arbiter.
// Revision: 1.0
`default_nettype none

interface vram_arbiter_if #(
  parameter int ADDR_W = 16
) ();
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              vid_valid;
  logic              vid_ovf;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vid_data, vid_valid, vid_ovf, cpu_rdata, cpu_ack, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_data, vid_valid, vid_ovf, cpu_rdata, cpu_ack, mem_addr, mem_wdata, mem_we
  );
endinterface

`default_nettype wire

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM slot arbiter, fixed-priority video fetch plus CPU handshake.
// Optional starvation guard with holding FIFO: VRAM_STARVE_GUARD_EN. Revision: 1.0
`default_nettype none

module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  typedef enum logic [2:0] {
    CPU_IDLE  = 3'd0,
    CPU_BUSY1 = 3'd1,
    CPU_BUSY2 = 3'd2,
    CPU_ACK   = 3'd3,
    CPU_HOLD  = 3'd4
  } cpu_st_e;

  cpu_st_e           cpu_st_q, cpu_st_d;
  tag_e              tag1_q, tag1_d, tag2_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_we_q, cpu_we_d;
  logic [7:0]        vid_data_q, cpu_rdata_q;
  logic              vid_valid_q;

  logic              cpu_idle_req;
  logic              force_cpu;
  logic              vid_slot;
  logic [ADDR_W-1:0] vid_slot_addr;
  logic              cpu_grant;

  assign cpu_idle_req = (cpu_st_q == CPU_IDLE) && bus.cpu_req;
  assign cpu_grant    = cpu_idle_req && !vid_slot;

`ifdef VRAM_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [1:0][ADDR_W-1:0] fifo_q, fifo_d;
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   fifo_ne, fifo_push, fifo_pop;

  assign fifo_ne       = (fifo_cnt_q != 2'd0);
  assign force_cpu     = cpu_idle_req && (wait_q >= WAIT_W'(STARVE_LIMIT));
  assign vid_slot      = !force_cpu && (fifo_ne || bus.vid_req);
  assign vid_slot_addr = fifo_ne ? fifo_q[0] : bus.vid_addr;
  // Once anything is queued, new requests queue behind it to keep video in order.
  assign fifo_push     = bus.vid_req && (force_cpu || fifo_ne);
  assign fifo_pop      = vid_slot && fifo_ne;
  assign bus.vid_ovf   = ovf_q;

  always_comb begin
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;
    ovf_d      = ovf_q;
    wait_d     = wait_q;
    if (fifo_pop) begin
      fifo_d[0]  = fifo_q[1];
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end
    if (fifo_push) begin
      if (fifo_cnt_d == 2'd2) begin
        ovf_d = 1'b1;
      end else begin
        fifo_d[fifo_cnt_d[0]] = bus.vid_addr;
        fifo_cnt_d            = fifo_cnt_d + 2'd1;
      end
    end
    if (cpu_grant) begin
      wait_d = '0;
    end else if (cpu_idle_req && (wait_q < WAIT_W'(STARVE_LIMIT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q     <= '0;
      fifo_cnt_q <= 2'd0;
      ovf_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      fifo_q     <= fifo_d;
      fifo_cnt_q <= fifo_cnt_d;
      ovf_q      <= ovf_d;
      wait_q     <= wait_d;
    end
  end
`else
  assign force_cpu     = 1'b0;
  assign vid_slot      = bus.vid_req;
  assign vid_slot_addr = bus.vid_addr;
  assign bus.vid_ovf   = 1'b0;
`endif

  always_comb begin
    cpu_st_d    = cpu_st_q;
    tag1_d      = TAG_NONE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cpu_we_d    = cpu_we_q;
    if (vid_slot) begin
      tag1_d     = TAG_VID;
      mem_addr_d = vid_slot_addr;
    end else if (cpu_grant) begin
      tag1_d     = TAG_CPU;
      mem_addr_d = bus.cpu_addr;
      mem_we_d   = bus.cpu_we;
      cpu_we_d   = bus.cpu_we;
      if (bus.cpu_we) begin
        mem_wdata_d = bus.cpu_wdata;
      end
    end
    case (cpu_st_q)
      CPU_IDLE:  if (cpu_grant) cpu_st_d = CPU_BUSY1;
      CPU_BUSY1: cpu_st_d = CPU_BUSY2;
      CPU_BUSY2: cpu_st_d = CPU_ACK;
      CPU_ACK:   cpu_st_d = CPU_HOLD;
      default:   cpu_st_d = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_st_q    <= CPU_IDLE;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_we_q    <= 1'b0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_st_q    <= cpu_st_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_we_q    <= cpu_we_d;
      vid_valid_q <= (tag2_q == TAG_VID);
      if (tag2_q == TAG_VID) begin
        vid_data_q <= bus.mem_rdata;
      end
      // Write transactions leave the last read value on CPU_RDATA.
      if ((tag2_q == TAG_CPU) && !cpu_we_q) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = (cpu_st_q == CPU_ACK);

endmodule

`default_nettype wire
